// File: rtl/count_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_disp_pkg
// Description : Shared constants for the count scan display: scan FSM state
//               encoding, active-low seven-segment digit patterns and
//               active-low anode enables.
// Revision    : 1.0 - initial release
// ============================================================================
package count_disp_pkg;

    // Scan FSM state encoding; one frame walks 0 -> 1 -> 2 -> 3 -> 0
    localparam logic [1:0] BLANK_ONES = 2'd0;
    localparam logic [1:0] SHOW_ONES  = 2'd1;
    localparam logic [1:0] BLANK_TENS = 2'd2;
    localparam logic [1:0] SHOW_TENS  = 2'd3;

    // Segment patterns {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Anode enables, active low; bit 0 = ones digit, bit 1 = tens digit
    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

endpackage : count_disp_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational decimal digit to active-low seven-segment
//               pattern. Codes 10..15 produce a dark digit.
// Ports       : i_digit [3:0] - digit code
//               o_seg   [6:0] - segments {g,f,e,d,c,b,a}, active low
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import count_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/count_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : count_scan_display
// Description : Displays an asynchronous 4-bit count (0..15) in decimal on a
//               two-digit multiplexed active-low seven-segment display with
//               leading-zero blanking. The count is synchronised and filtered,
//               and the displayed value only changes at frame boundaries.
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous reset, active low
//               count[3:0] - binary count, asynchronous to clk
//               an[1:0]    - digit enables, active low (0 = ones, 1 = tens)
//               seg[6:0]   - segments {g,f,e,d,c,b,a}, active low
//               dp         - decimal point, active low, always off
// Revision    : 1.0 - initial release
// ============================================================================
module count_scan_display
    import count_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] count,
    output logic [1:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    // Prescaler must reach the larger of the two phase lengths minus one
    localparam int MAXN = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int PW   = (MAXN > 2) ? $clog2(MAXN) : 1;

    localparam logic [PW-1:0] c_scan_last  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] c_blank_last = PW'(BLANK_CYC - 1);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_sync2_prev;
    logic [3:0]    r_accepted;
    logic [3:0]    r_shadow;
    logic [1:0]    r_state;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_an;
    logic [6:0]    r_seg;

    logic [1:0]    w_state_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [1:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_last;
    logic          w_load;
    logic          w_tens;
    logic [3:0]    w_ones;
    logic [6:0]    w_ones_seg;

    // ------------------------------------------------------------------
    // Input conditioning: two-flop synchroniser, then accept only a value
    // that has been seen on two consecutive cycles so that a skewed
    // multi-bit transition or a one-cycle glitch never reaches the display.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= 4'd0;
            r_sync2      <= 4'd0;
            r_sync2_prev <= 4'd0;
            r_accepted   <= 4'd0;
        end else begin
            r_sync1      <= count;
            r_sync2      <= r_sync1;
            r_sync2_prev <= r_sync2;
            if (r_sync2 == r_sync2_prev) begin
                r_accepted <= r_sync2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decimal split of the frame image
    // ------------------------------------------------------------------
    assign w_tens = (r_shadow >= 4'd10);
    assign w_ones = w_tens ? (r_shadow - 4'd10) : r_shadow;

    seg7_decode u_seg7_decode (
        .i_digit (w_ones),
        .o_seg   (w_ones_seg)
    );

    // ------------------------------------------------------------------
    // Scan FSM: next state, prescaler and registered outputs. Outputs are
    // computed from the next state so they change on the same edge as the
    // state register.
    // ------------------------------------------------------------------
    always_comb begin
        w_last      = 1'b0;
        w_state_nxt = r_state;
        w_presc_nxt = r_presc + 1'b1;
        w_an_nxt    = AN_OFF;
        w_seg_nxt   = SEG_OFF;

        case (r_state)
            BLANK_ONES: w_last = (r_presc == c_blank_last);
            SHOW_ONES:  w_last = (r_presc == c_scan_last);
            BLANK_TENS: w_last = (r_presc == c_blank_last);
            SHOW_TENS:  w_last = (r_presc == c_scan_last);
        endcase

        if (w_last) begin
            w_presc_nxt = '0;
            case (r_state)
                BLANK_ONES: w_state_nxt = SHOW_ONES;
                SHOW_ONES:  w_state_nxt = BLANK_TENS;
                BLANK_TENS: w_state_nxt = SHOW_TENS;
                SHOW_TENS:  w_state_nxt = BLANK_ONES;
            endcase
        end

        case (w_state_nxt)
            SHOW_ONES: begin
                w_an_nxt  = AN_ONES;
                w_seg_nxt = w_ones_seg;
            end
            SHOW_TENS: begin
                // Tens digit is only ever 1; a zero tens digit stays dark
                if (w_tens) begin
                    w_an_nxt  = AN_TENS;
                    w_seg_nxt = SEG_1;
                end
            end
            default: begin
                w_an_nxt  = AN_OFF;
                w_seg_nxt = SEG_OFF;
            end
        endcase
    end

    // The frame image is latched only when a frame completes
    assign w_load = (r_state == SHOW_TENS) && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= BLANK_ONES;
            r_presc  <= '0;
            r_an     <= AN_OFF;
            r_seg    <= SEG_OFF;
            r_shadow <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            if (w_load) begin
                r_shadow <= r_accepted;
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule : count_scan_display
`default_nettype wire

// File: tb/tb_count_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_scan_display
// Description : Directed self-checking bench for count_scan_display with
//               SCAN_DIV=4, BLANK_CYC=2 (12-cycle frame). Every output is
//               compared on the falling edge against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_scan_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 2 * (SCAN_DIV + BLANK_CYC);

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] count = 4'd0;
    logic [1:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    count_scan_display #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Checks one frame starting at a falling edge where sample 0 is the first
    // BLANK_ONES cycle. Optionally drives count changes after given samples,
    // or asserts reset after a given sample and returns.
    task automatic run_frame(input string name, input logic [6:0] ones_seg, input bit tens_on,
                             input int chg_at, input logic [3:0] chg_val,
                             input int chg2_at, input logic [3:0] chg2_val,
                             input int rst_at);
        for (int i = 0; i < FRAME; i++) begin
            logic [1:0] ea;
            logic [6:0] es;
            if (i < 2 || (i >= 6 && i < 8)) begin
                ea = 2'b11; es = 7'h7F;
            end else if (i < 6) begin
                ea = 2'b10; es = ones_seg;
            end else if (tens_on) begin
                ea = 2'b01; es = 7'h79;
            end else begin
                ea = 2'b11; es = 7'h7F;
            end
            check($sformatf("%s an[%0d]", name, i), {14'd0, an}, {14'd0, ea});
            check($sformatf("%s seg[%0d]", name, i), {9'd0, seg}, {9'd0, es});
            check($sformatf("%s dp[%0d]", name, i), {15'd0, dp}, 16'd1);
            if (i == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                check($sformatf("%s async_rst an", name), {14'd0, an}, 16'h0003);
                check($sformatf("%s async_rst seg", name), {9'd0, seg}, 16'h007F);
                return;
            end
            if (i == chg_at)  count = chg_val;
            if (i == chg2_at) count = chg2_val;
            @(negedge clk);
        end
    endtask

    initial begin
        count = 4'd5;
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset an", {14'd0, an}, 16'h0003);
            check("reset seg", {9'd0, seg}, 16'h007F);
            check("reset dp", {15'd0, dp}, 16'd1);
        end
        rst_n = 1'b1;

        // Frame 0 shows the reset shadow value 0; count=5 held throughout
        run_frame("f0_zero",  7'h40, 1'b0, -1, 4'd0, -1, 4'd0, -1);
        // 5 displayed; change to 9 during SHOW_ONES must not affect this frame
        run_frame("f1_five",  7'h12, 1'b0,  3, 4'd9, -1, 4'd0, -1);
        run_frame("f2_nine",  7'h10, 1'b0,  0, 4'd13, -1, 4'd0, -1);
        run_frame("f3_13",    7'h30, 1'b1,  0, 4'd5, -1, 4'd0, -1);
        // One-cycle glitch to 2 must never be accepted
        run_frame("f4_five",  7'h12, 1'b0,  2, 4'd2,  3, 4'd5, -1);
        run_frame("f5_glitch",7'h12, 1'b0,  0, 4'd15, -1, 4'd0, -1);
        // Wrap 15 -> 0
        run_frame("f6_15",    7'h12, 1'b1,  0, 4'd0, -1, 4'd0, -1);
        run_frame("f7_wrap0", 7'h40, 1'b0,  0, 4'd13, -1, 4'd0, -1);
        // Reset asserted during SHOW_TENS of a "13" frame
        run_frame("f8_13rst", 7'h30, 1'b1, -1, 4'd0, -1, 4'd0, 9);

        repeat (3) begin
            @(negedge clk);
            check("held_rst an", {14'd0, an}, 16'h0003);
            check("held_rst seg", {9'd0, seg}, 16'h007F);
        end
        rst_n = 1'b1;

        // Restart: shadow cleared so the first frame shows 0, then 13 again
        run_frame("r0_zero",  7'h40, 1'b0, -1, 4'd0, -1, 4'd0, -1);
        run_frame("r1_13",    7'h30, 1'b1, -1, 4'd0, -1, 4'd0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_count_scan_display
`default_nettype wire
